// File: rtl/fsm_alu_ext.sv
// Control sequencer for integer ALU-class instructions (OP, OP-IMM, OP-32, OP-IMM-32)
// with optional M-extension handshake and illegal-encoding detection.
module fsm_alu_ext #(
    parameter int XLEN  = 64,
    parameter bit HAS_M = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic        start,
    input  logic        md_done,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [2:0]  func3,
    output logic        load_rs1,
    output logic        load_rs2,
    output logic        load_alu,
    output logic        load_regfile,
    output logic        load_pc,
    output logic        sel_alu_b,
    output logic        sub_sra,
    output logic        word_op,
    output logic [1:0]  sel_rd,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXEC_R    = 3'd2;
    localparam logic [2:0] S_EXEC_I    = 3'd3;
    localparam logic [2:0] S_MD_START  = 3'd4;
    localparam logic [2:0] S_MD_WAIT   = 3'd5;
    localparam logic [2:0] S_WRITEBACK = 3'd6;
    localparam logic [2:0] S_TRAP      = 3'd7;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    logic [2:0] state;
    logic [2:0] next_state;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] f3;
    logic       is_reg;
    logic       is_imm;
    logic       is_word;
    logic       is_md;
    logic       is_shift_imm;
    logic       bad_enc;

    assign rs1_addr = ins[19:15];
    assign rs2_addr = ins[24:20];
    assign rd_addr  = ins[11:7];
    assign func3    = ins[14:12];

    assign opcode = ins[6:0];
    assign funct7 = ins[31:25];
    assign f3     = ins[14:12];

    always_comb begin
        is_reg       = (opcode == OPC_OP) || (opcode == OPC_OP_32);
        is_imm       = (opcode == OPC_OP_IMM) || (opcode == OPC_OP_IMM_32);
        is_word      = (opcode == OPC_OP_32) || (opcode == OPC_OP_IMM_32);
        is_md        = is_reg && (funct7 == F7_MD) && HAS_M;
        is_shift_imm = is_imm && ((f3 == 3'b001) || (f3 == 3'b101));

        bad_enc = !(is_reg || is_imm)
               || (is_word && (XLEN == 32))
               || (is_reg && !((funct7 == F7_BASE) || (funct7 == F7_ALT) || (funct7 == F7_MD)))
               || (is_reg && (funct7 == F7_MD) && !HAS_M)
               || (is_reg && (funct7 == F7_ALT) && !((f3 == 3'b000) || (f3 == 3'b101)))
               || (is_shift_imm && ins[25] && ((opcode == OPC_OP_IMM_32) || (XLEN == 32)))
               || ((opcode == OPC_OP_IMM_32) && !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101)));
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = S_IDLE;
        case (state)
            S_IDLE:      next_state = start ? S_DECODE : S_IDLE;
            S_DECODE: begin
                if (bad_enc)     next_state = S_TRAP;
                else if (is_md)  next_state = S_MD_START;
                else if (is_reg) next_state = S_EXEC_R;
                else             next_state = S_EXEC_I;
            end
            S_EXEC_R:    next_state = S_WRITEBACK;
            S_EXEC_I:    next_state = S_WRITEBACK;
            S_MD_START:  next_state = S_MD_WAIT;
            S_MD_WAIT:   next_state = md_done ? S_WRITEBACK : S_MD_WAIT;
            S_WRITEBACK: next_state = S_IDLE;
            S_TRAP:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Strobes are registered from next_state so each is high exactly while in its state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state        <= S_IDLE;
            load_rs1     <= 1'b0;
            load_rs2     <= 1'b0;
            load_alu     <= 1'b0;
            load_regfile <= 1'b0;
            load_pc      <= 1'b0;
            sel_alu_b    <= 1'b0;
            sub_sra      <= 1'b0;
            word_op      <= 1'b0;
            sel_rd       <= 2'b00;
            md_start     <= 1'b0;
            md_op        <= 3'b000;
            busy         <= 1'b0;
            done         <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            state        <= next_state;
            load_rs1     <= (next_state == S_DECODE);
            load_rs2     <= (next_state == S_DECODE);
            load_alu     <= (next_state == S_EXEC_R) || (next_state == S_EXEC_I);
            sel_alu_b    <= (next_state == S_EXEC_I);
            // Immediate forms only honour ins[30] for right shifts; ADDI never subtracts.
            sub_sra      <= ((next_state == S_EXEC_R) && ins[30])
                         || ((next_state == S_EXEC_I) && ins[30] && (f3 == 3'b101));
            word_op      <= is_word && ((next_state == S_EXEC_R) || (next_state == S_EXEC_I)
                         || (next_state == S_MD_START) || (next_state == S_MD_WAIT)
                         || (next_state == S_WRITEBACK));
            md_start     <= (next_state == S_MD_START);
            md_op        <= (next_state == S_MD_START) ? f3 : 3'b000;
            load_pc      <= (next_state == S_WRITEBACK);
            done         <= (next_state == S_WRITEBACK);
            load_regfile <= (next_state == S_WRITEBACK) && (ins[11:7] != 5'd0);
            sel_rd       <= ((next_state == S_WRITEBACK) && (state == S_MD_WAIT)) ? 2'b01 : 2'b00;
            illegal      <= (next_state == S_TRAP);
            busy         <= (next_state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_fsm_alu_ext.sv
// Randomized self-checking bench for fsm_alu_ext: two instances (XLEN=64/HAS_M=1 and
// XLEN=32/HAS_M=0) share stimulus and are compared cycle by cycle against a class-level model.
`timescale 1ns/1ps
module tb_fsm_alu_ext;

    typedef struct packed {
        logic       load_rs1;
        logic       load_rs2;
        logic       load_alu;
        logic       load_regfile;
        logic       load_pc;
        logic       sel_alu_b;
        logic       sub_sra;
        logic       word_op;
        logic [1:0] sel_rd;
        logic       md_start;
        logic [2:0] md_op;
        logic       busy;
        logic       done;
        logic       illegal;
    } ctl_t;

    localparam int C_ILL = 0;
    localparam int C_R   = 1;
    localparam int C_I   = 2;
    localparam int C_MD  = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] ins;
    logic        start;
    logic        md_done;

    logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
    logic [2:0] a_f3, b_f3, a_mdop, b_mdop;
    logic [1:0] a_selrd, b_selrd;
    logic a_lrs1, a_lrs2, a_lalu, a_lrf, a_lpc, a_selb, a_sub, a_word, a_mds, a_busy, a_done, a_ill;
    logic b_lrs1, b_lrs2, b_lalu, b_lrf, b_lpc, b_selb, b_sub, b_word, b_mds, b_busy, b_done, b_ill;

    int n_checks = 0;
    int n_pass   = 0;

    fsm_alu_ext #(.XLEN(64), .HAS_M(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .ins(ins), .start(start), .md_done(md_done),
        .rs1_addr(a_rs1), .rs2_addr(a_rs2), .rd_addr(a_rd), .func3(a_f3),
        .load_rs1(a_lrs1), .load_rs2(a_lrs2), .load_alu(a_lalu), .load_regfile(a_lrf),
        .load_pc(a_lpc), .sel_alu_b(a_selb), .sub_sra(a_sub), .word_op(a_word),
        .sel_rd(a_selrd), .md_start(a_mds), .md_op(a_mdop), .busy(a_busy),
        .done(a_done), .illegal(a_ill)
    );

    fsm_alu_ext #(.XLEN(32), .HAS_M(1'b0)) dut32 (
        .clk(clk), .rst_n(rst_n), .ins(ins), .start(start), .md_done(md_done),
        .rs1_addr(b_rs1), .rs2_addr(b_rs2), .rd_addr(b_rd), .func3(b_f3),
        .load_rs1(b_lrs1), .load_rs2(b_lrs2), .load_alu(b_lalu), .load_regfile(b_lrf),
        .load_pc(b_lpc), .sel_alu_b(b_selb), .sub_sra(b_sub), .word_op(b_word),
        .sel_rd(b_selrd), .md_start(b_mds), .md_op(b_mdop), .busy(b_busy),
        .done(b_done), .illegal(b_ill)
    );

    ctl_t obs_a, obs_b;
    assign obs_a = '{a_lrs1, a_lrs2, a_lalu, a_lrf, a_lpc, a_selb, a_sub, a_word,
                     a_selrd, a_mds, a_mdop, a_busy, a_done, a_ill};
    assign obs_b = '{b_lrs1, b_lrs2, b_lalu, b_lrf, b_lpc, b_selb, b_sub, b_word,
                     b_selrd, b_mds, b_mdop, b_busy, b_done, b_ill};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv)
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        else
            n_pass++;
    endtask

    // Instruction class straight from the encoding rules.
    function automatic int classify(input logic [31:0] i, input int xlen, input bit has_m);
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        bit         w;
        opc = i[6:0];
        f7  = i[31:25];
        f3  = i[14:12];
        if (opc == 7'h33 || opc == 7'h3B) begin
            w = (opc == 7'h3B);
            if (w && xlen == 32) return C_ILL;
            if (f7 == 7'h01) return has_m ? C_MD : C_ILL;
            if (f7 == 7'h00) return C_R;
            if (f7 == 7'h20) return (f3 == 3'd0 || f3 == 3'd5) ? C_R : C_ILL;
            return C_ILL;
        end
        if (opc == 7'h13 || opc == 7'h1B) begin
            w = (opc == 7'h1B);
            if (w && xlen == 32) return C_ILL;
            if (w && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) return C_ILL;
            if ((f3 == 3'd1 || f3 == 3'd5) && i[25] && (w || xlen == 32)) return C_ILL;
            return C_I;
        end
        return C_ILL;
    endfunction

    // First cycle (counted from the start-sampling edge) at which the FSM is idle again.
    function automatic int idle_cycle(input int cls, input int d);
        case (cls)
            C_ILL:   return 3;
            C_MD:    return d + 2;
            default: return 4;
        endcase
    endfunction

    // Expected control outputs during cycle k; md_done is raised during cycle d.
    function automatic ctl_t expect_at(input int cls, input logic [31:0] i, input int k, input int d);
        ctl_t e;
        bit   w;
        e = '0;
        w = (i[6:0] == 7'h3B) || (i[6:0] == 7'h1B);
        if (k == 1) begin
            e.load_rs1 = 1'b1;
            e.load_rs2 = 1'b1;
            e.busy     = 1'b1;
        end else if (cls == C_ILL) begin
            if (k == 2) begin
                e.illegal = 1'b1;
                e.busy    = 1'b1;
            end
        end else if (cls == C_R || cls == C_I) begin
            if (k == 2) begin
                e.load_alu  = 1'b1;
                e.sel_alu_b = (cls == C_I);
                e.sub_sra   = (cls == C_R) ? i[30] : (i[30] && i[14:12] == 3'd5);
                e.word_op   = w;
                e.busy      = 1'b1;
            end else if (k == 3) begin
                e.load_pc      = 1'b1;
                e.done         = 1'b1;
                e.load_regfile = (i[11:7] != 5'd0);
                e.word_op      = w;
                e.busy         = 1'b1;
            end
        end else begin
            if (k == 2) begin
                e.md_start = 1'b1;
                e.md_op    = i[14:12];
                e.word_op  = w;
                e.busy     = 1'b1;
            end else if (k <= d) begin
                e.word_op = w;
                e.busy    = 1'b1;
            end else if (k == d + 1) begin
                e.load_pc      = 1'b1;
                e.done         = 1'b1;
                e.load_regfile = (i[11:7] != 5'd0);
                e.word_op      = w;
                e.sel_rd       = 2'b01;
                e.busy         = 1'b1;
            end
        end
        return e;
    endfunction

    // Entered and left #1 after a rising edge with both instances idle.
    task automatic run_ins(input logic [31:0] i, input int d, input bit noise);
        int cls_a, cls_b, la, lb, lmin, lmax;
        cls_a = classify(i, 64, 1'b1);
        cls_b = classify(i, 32, 1'b0);
        la    = idle_cycle(cls_a, d);
        lb    = idle_cycle(cls_b, d);
        lmin  = (la < lb) ? la : lb;
        lmax  = (la > lb) ? la : lb;
        ins     = i;
        start   = 1'b1;
        md_done = 1'b0;
        #1;
        check($sformatf("fields %h", i), {12'd0, a_rs1, a_rs2, a_rd, a_f3},
              {12'd0, i[19:15], i[24:20], i[11:7], i[14:12]});
        @(posedge clk); #1;
        for (int k = 1; k <= lmax; k++) begin
            start   = noise && (k < lmin) && ($urandom_range(0, 1) == 1);
            md_done = (k == d) || ((k <= 2) && ($urandom_range(0, 1) == 1));
            @(negedge clk);
            check($sformatf("x64 %h c%0d", i, k), 32'(obs_a), 32'(expect_at(cls_a, i, k, d)));
            check($sformatf("x32 %h c%0d", i, k), 32'(obs_b), 32'(expect_at(cls_b, i, k, d)));
            @(posedge clk); #1;
        end
        start   = 1'b0;
        md_done = 1'b0;
    endtask

    logic [31:0] directed [7];
    logic [6:0]  opcs [5];
    logic [6:0]  f7s  [4];

    initial begin
        directed[0] = 32'h002081B3;  // ADD x3,x1,x2
        directed[1] = 32'h4032D293;  // SRAI x5,x5,3
        directed[2] = 32'h0032D293;  // SRLI x5,x5,3
        directed[3] = 32'hFFF00093;  // ADDI x1,x0,-1
        directed[4] = 32'h003100BB;  // ADDW x1,x2,x3
        directed[5] = 32'h02208233;  // MUL x4,x1,x2
        directed[6] = 32'h00208033;  // ADD x0,x1,x2
        opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h3B; opcs[3] = 7'h1B; opcs[4] = 7'h03;
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'h11;

        rst_n   = 1'b0;
        start   = 1'b0;
        md_done = 1'b0;
        ins     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset x64", 32'(obs_a), 32'h0);
        check("reset x32", 32'(obs_b), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MUL with md_done in cycle 6 completes in 8 cycles start-to-idle.
        for (int j = 0; j < 7; j++)
            run_ins(directed[j], (j == 5) ? 6 : 3, j == 6);

        // Reset while the 64-bit instance sits in MD_WAIT; a late md_done must be ignored.
        ins   = 32'h02208233;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("md_wait busy", {31'd0, a_busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        @(negedge clk);
        check("midreset x64", 32'(obs_a), 32'h0);
        check("midreset x32", 32'(obs_b), 32'h0);
        md_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            md_done = (k == 0);
            @(negedge clk);
            check($sformatf("late md_done x64 %0d", k), 32'(obs_a), 32'h0);
        end
        @(posedge clk); #1;
        md_done = 1'b0;
        run_ins(32'h02208233, 3 + $urandom_range(0, 3), 1'b1);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] r;
            r       = $urandom;
            r[6:0]  = opcs[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) != 0)
                r[31:25] = f7s[$urandom_range(0, 3)];
            run_ins(r, 3 + $urandom_range(0, 4), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
